// File: rtl/griffin_round_sched.sv
// Round scheduler for the Griffin permutation: owns the state register and sequences
// the initial linear layer, then NUM_ROUNDS of (nonlinear, affine) through external units.
module griffin_round_sched #(
  parameter int N_BITS         = 254,
  parameter int STATE_SIZE     = 3,
  parameter int NUM_ROUNDS     = 12,
  parameter int AFFINE_LATENCY = 1,
  parameter int RC_AW          = $clog2(NUM_ROUNDS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_BITS*STATE_SIZE-1:0]   in_state,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_BITS*STATE_SIZE-1:0]   out_state,
  output logic                           busy,
  output logic [N_BITS*STATE_SIZE-1:0]   aff_state,
  output logic [RC_AW-1:0]               rc_addr,
  output logic                           rc_zero,
  input  logic [N_BITS*STATE_SIZE-1:0]   aff_result,
  output logic                           nl_valid,
  input  logic                           nl_ready,
  output logic [N_BITS*STATE_SIZE-1:0]   nl_state,
  input  logic                           nl_res_valid,
  input  logic [N_BITS*STATE_SIZE-1:0]   nl_result
);

  localparam int SW    = N_BITS * STATE_SIZE;
  localparam int RND_W = $clog2(NUM_ROUNDS + 1);
  localparam int WC_W  = (AFFINE_LATENCY < 1) ? 1 : $clog2(AFFINE_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AFF      = 3'd1,
    NL_ISSUE = 3'd2,
    NL_WAIT  = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e           state_q;
  logic [SW-1:0]    st_q;
  logic [RND_W-1:0] rnd_q;
  logic [WC_W-1:0]  wc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      wc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q    <= in_state;
            rnd_q   <= '0;
            wc_q    <= '0;
            state_q <= AFF;
          end
        end
        AFF: begin
          // Inputs to the affine datapath stay frozen until its result is taken.
          if (wc_q == WC_W'(AFFINE_LATENCY)) begin
            st_q <= aff_result;
            if (rnd_q == RND_W'(NUM_ROUNDS)) begin
              state_q <= DONE;
            end else begin
              rnd_q   <= rnd_q + RND_W'(1);
              state_q <= NL_ISSUE;
            end
          end else begin
            wc_q <= wc_q + WC_W'(1);
          end
        end
        NL_ISSUE: begin
          if (nl_ready) state_q <= NL_WAIT;
        end
        NL_WAIT: begin
          if (nl_res_valid) begin
            st_q    <= nl_result;
            wc_q    <= '0;
            state_q <= AFF;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so none depends combinationally on inputs.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign nl_valid  = (state_q == NL_ISSUE);
  assign rc_zero   = (state_q == AFF) && (rnd_q == '0);
  assign rc_addr   = (rnd_q != '0) ? RC_AW'(rnd_q - RND_W'(1)) : '0;
  assign out_state = st_q;
  assign aff_state = st_q;
  assign nl_state  = st_q;

endmodule

// File: doc/griffin_round_sched.md
# griffin_round_sched

Round scheduler for the Griffin permutation core. It owns the permutation state register and handles one permutation at a time. It runs the initial linear layer, then NUM_ROUNDS rounds of nonlinear layer plus affine layer. It drives the external 3-element affine datapath (1-cycle registered adder stage) and an external nonlinear-layer unit through a request/response handshake, supplying the round-constant address for each affine pass.

## Interface
- N_BITS, 254, field element width
- STATE_SIZE, 3, state elements
- NUM_ROUNDS, 12, nonlinear+affine rounds after the initial linear layer
- AFFINE_LATENCY, 1, register stages inside the affine datapath
- RC_AW, $clog2(NUM_ROUNDS), round-constant address width
- clk  input  1  clock; all logic on posedge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  new input state offered
- in_ready  output  1  high only in IDLE
- in_state  input  N_BITS×STATE_SIZE  permutation input
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_state  output  N_BITS×STATE_SIZE  permutation result; equals state register
- busy  output  1  high in every state except IDLE
- aff_state  output  N_BITS×STATE_SIZE  affine datapath input; equals state register
- rc_addr  output  RC_AW  round-constant ROM address for the current affine pass
- rc_zero  output  1  forces round constants to zero (initial linear layer)
- aff_result  input  N_BITS×STATE_SIZE  affine datapath output
- nl_valid  output  1  nonlinear request
- nl_ready  input  1  nonlinear unit accepts request
- nl_state  output  N_BITS×STATE_SIZE  nonlinear input; equals state register
- nl_res_valid  input  1  nonlinear result strobe, single cycle
- nl_result  input  N_BITS×STATE_SIZE  nonlinear output

## Operation
- States: IDLE, AFF, NL_ISSUE, NL_WAIT, DONE. Round counter `rnd` runs 0..NUM_ROUNDS. Wait counter `wc` runs 0..AFFINE_LATENCY.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_state into st, set rnd=0 and wc=0, go to AFF.
- AFF:
  - st, rc_addr and rc_zero stay stable for the whole state.
  - rc_zero=1 iff rnd==0. rc_addr=rnd-1 when rnd≥1, else 0.
  - wc increments each cycle.
  - On the cycle with wc==AFFINE_LATENCY, capture aff_result into st.
  - Then, if rnd==NUM_ROUNDS, go to DONE. Otherwise set rnd+=1 and go to NL_ISSUE.
- NL_ISSUE:
  - nl_valid=1.
  - On nl_ready, go to NL_WAIT. nl_valid stays high until accepted.
- NL_WAIT:
  - On nl_res_valid, capture nl_result into st, clear wc, go to AFF.
  - nl_res_valid in any other state is ignored; st is unchanged.
- DONE:
  - out_valid=1.
  - On out_ready, go to IDLE.
  - out_state holds steady while stalled.
- in_valid outside IDLE is ignored; in_ready=0 there.
- No arithmetic is done here. st is a plain register with N_BITS per element. The counters saturate structurally and never wrap.

## Timing
- Reset (async assert, sync release):
  - State IDLE, st=0, rnd=0, wc=0.
  - in_ready=1; out_valid=0, nl_valid=0, busy=0.
  - rc_addr=0, rc_zero=0 (rc_zero qualified by state).
- Reset asserted mid-permutation aborts immediately and the state returns to IDLE. A late nl_res_valid after release is ignored.
- Each AFF visit lasts exactly AFFINE_LATENCY+1 cycles.
- The nonlinear unit accepts the request the same cycle (nl_ready=1) and returns nl_res_valid L cycles after acceptance.
- Under those conditions, the in_valid-accept edge to the first out_valid cycle is (A+1) + NUM_ROUNDS·(A+2+L) cycles, where A=AFFINE_LATENCY.
  - Default A=1, L=1: 2+12·4 = 50 cycles.
- Output handshake:
  - out_valid rises one cycle after the last affine capture.
  - out_ready held high accepts in the first DONE cycle; in_ready is high the next cycle.
  - Back-to-back throughput is one permutation per latency+2 cycles.
- rc_addr sequence across a permutation: the initial pass (rc_zero=1), then 0,1,…,NUM_ROUNDS-1.

## Test plan
- Reset with in_valid=1 and nl_res_valid=1 held → all outputs at reset values, st=0, no transition before rst_n release.
- Single permutation: nl_ready=1, L=1, behavioural affine model (A=1), out_ready=1 → out_valid first high at cycle 50 after accept; out_state matches the Griffin golden model for input (0,1,2); rc_addr sequence is rc_zero,0..11.
- Stalls: nl_ready low 3 cycles per round, L=5, out_ready low 4 cycles in DONE → nl_valid held until acceptance, out_state stable through the stall, result identical to the unstalled run.
- Spurious strobes: nl_res_valid pulsed in AFF and NL_ISSUE, in_valid pulsed while busy → st unaffected, no second permutation started, result unchanged.
- Reset mid-run: assert rst_n=0 during NL_WAIT of round 5, release, then issue a new input → clean IDLE; the second permutation completes correctly in 50 cycles.
- Back-to-back: two inputs with in_valid always high, out_ready=1 → second accepted the cycle after the first out_valid handshake; both results correct.
